imm_ext_stage: RTL and testbench
================================

Name: imm_ext_stage

Overview:
Parametrised, registered immediate-extension stage for the decode pipeline. It takes instr[31:7] and imm_src, computes the XLEN-wide immediate, and buffers the result in a 2-entry elastic buffer with valid/ready handshakes on both sides. It supports RV32 and RV64, adds CSR-zimm and zero-extended-I modes, flags illegal imm_src values, and supports pipeline flush. It sits between the instruction decoder and the ID/EX register.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
TAG_W, 32, width of the sideband tag (PC or ROB id) carried alongside each immediate.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous flush; discards all buffered entries
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept; registered
instr  input  25  instruction bits [31:7]
imm_src  input  3  immediate format select
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  imm_ext/out_tag/out_illegal valid
out_ready  input  1  downstream accepts
imm_ext  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of the head entry
out_illegal  output  1  head entry had a reserved imm_src

Behaviour:
- Formats (s = instr[31] replicated to XLEN):
  - 000 I: s, instr[31:20].
  - 001 S: s, instr[31:25], instr[11:7].
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: s, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: s, instr[31:12], 12'b0. For XLEN=64, bits [63:32] = instr[31].
  - 101 Z: zero-extended instr[19:15] (CSR zimm).
  - 110 IU: zero-extended instr[31:20].
  - 111 reserved: imm_ext = 0, illegal = 1.
- Extension is combinational on the input side; the buffer stores {imm, tag, illegal}.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Latency: an entry accepted at edge N is visible at the head after edge N (1 cycle), provided the buffer was empty.
- Ordering: strict FIFO.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1. Push → ONE.
  - ONE: out_valid=1, in_ready=1. Push without pop → FULL. Pop without push → EMPTY. Push and pop together → stays ONE; head replaced by the new entry.
  - FULL: out_valid=1, in_ready=0. Pop → ONE, with the second entry promoted to head. in_valid is ignored.
- in_ready is a registered function of next-state: it is 0 exactly when the next state is FULL. It never depends combinationally on out_ready.
- Head outputs hold stable while out_valid && !out_ready.
- flush:
  - Next state is EMPTY and in_ready is 1 next cycle.
  - flush overrides a simultaneous push or pop; the pushed entry is dropped.
- Reset (reset_n low, asynchronous, including mid-transfer):
  - State EMPTY, out_valid=0, in_ready=1, imm_ext=0, out_tag=0, out_illegal=0.
  - Release is synchronised externally; the first edge after deassertion may accept.
- Outputs when out_valid=0: imm_ext/out_tag/out_illegal hold their last value (0 after reset). Bench must not check them.
- No X propagation: buffer storage is reset to 0.
- Upstream must hold in_valid and its data until accepted. Downstream may drop out_ready at any time.

Test Plan:
- Reset, XLEN=32. I-type instr[31:20]=0xFFF, imm_src=000, out_ready=1 → out_valid one cycle after accept, imm_ext=0xFFFFFFFF, out_illegal=0.
- B-type with instr[31]=1, [30:25]=111111, [11:8]=1110, [7]=1 → imm_ext=0xFFFFFFFC. Repeat with XLEN=64 → 0xFFFFFFFFFFFFFFFC. U-type instr[31:12]=0x80000 with XLEN=64 → 0xFFFFFFFF80000000. Z mode with instr[19:15]=10101 → 0x15. imm_src=111 → imm_ext=0, out_illegal=1.
- Backpressure: out_ready=0, push tags A, B, C back-to-back.
  - A and B are accepted; in_ready=0 after B; C is held upstream.
  - Raise out_ready → order A, B, C.
  - in_ready returns to 1 one cycle after the first pop.
- Simultaneous push/pop in ONE with out_ready=1 and continuous in_valid → one result per cycle, state stays ONE, tags sequential, no bubbles.
- flush asserted in FULL together with in_valid → next cycle out_valid=0, in_ready=1; the pushed entry never appears at the output.
- reset_n pulsed low asynchronously mid-cycle while FULL → outputs zero and out_valid=0 immediately (before the next edge); after release, normal operation resumes with in_ready=1.

Source files
------------

// File: rtl/imm_ext_stage.sv
// Decode-side immediate extension with a 2-entry elastic output buffer.
// Head/tail registers carry {imm, tag, illegal}; a 3-state FSM tracks occupancy.
module imm_ext_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : gBadXlen
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // instr[k] lives at ins[k-7]; signed fields sign-extend through the size cast.
  function automatic logic [XLEN-1:0] extendImm(input logic [24:0] ins,
                                                input logic [2:0]  src);
    logic signed [11:0] iImm;
    logic signed [11:0] sImm;
    logic signed [12:0] bImm;
    logic signed [20:0] jImm;
    logic signed [31:0] uImm;
    logic [XLEN-1:0]    res;
    iImm = ins[24:13];
    sImm = {ins[24:18], ins[4:0]};
    bImm = {ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
    jImm = {ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
    uImm = {ins[24:5], 12'b0};
    case (src)
      3'b000:  res = XLEN'(iImm);
      3'b001:  res = XLEN'(sImm);
      3'b010:  res = XLEN'(bImm);
      3'b011:  res = XLEN'(jImm);
      3'b100:  res = XLEN'(uImm);
      3'b101:  res = XLEN'(ins[12:8]);
      3'b110:  res = XLEN'(ins[24:13]);
      default: res = '0;
    endcase
    return res;
  endfunction

  state_t state, stateNext;
  logic   inReadyReg;
  logic   push, pop;
  logic   loadHead, loadTail, promote;

  // ---- stage p0: combinational extension of the incoming instruction
  logic [XLEN-1:0] immNew_p0;
  logic            illNew_p0;

  assign immNew_p0 = extendImm(instr, imm_src);
  assign illNew_p0 = (imm_src == 3'b111);

  // ---- stage p1: buffered entries and occupancy control
  logic [XLEN-1:0]  headImm_p1, tailImm_p1;
  logic [TAG_W-1:0] headTag_p1, tailTag_p1;
  logic             headIll_p1, tailIll_p1;
  logic             vld_p1;

  assign vld_p1 = (state != EMPTY);
  assign push   = in_valid && in_ready;
  assign pop    = vld_p1 && out_ready;

  always_comb begin
    stateNext = state;
    loadHead  = 1'b0;
    loadTail  = 1'b0;
    promote   = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          stateNext = ONE;
          loadHead  = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            stateNext = FULL;
            loadTail  = 1'b1;
          end
          2'b01: stateNext = EMPTY;
          2'b11: loadHead = 1'b1;
          default: stateNext = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          stateNext = ONE;
          promote   = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Flush wins over any concurrent push or pop; storage keeps its stale value.
    if (flush) begin
      stateNext = EMPTY;
      loadHead  = 1'b0;
      loadTail  = 1'b0;
      promote   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      inReadyReg <= 1'b1;
    end else begin
      state      <= stateNext;
      inReadyReg <= (stateNext != FULL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      headImm_p1 <= '0;
      headTag_p1 <= '0;
      headIll_p1 <= 1'b0;
      tailImm_p1 <= '0;
      tailTag_p1 <= '0;
      tailIll_p1 <= 1'b0;
    end else begin
      if (loadHead) begin
        headImm_p1 <= immNew_p0;
        headTag_p1 <= in_tag;
        headIll_p1 <= illNew_p0;
      end else if (promote) begin
        headImm_p1 <= tailImm_p1;
        headTag_p1 <= tailTag_p1;
        headIll_p1 <= tailIll_p1;
      end
      if (loadTail) begin
        tailImm_p1 <= immNew_p0;
        tailTag_p1 <= in_tag;
        tailIll_p1 <= illNew_p0;
      end
    end
  end

  assign in_ready    = inReadyReg;
  assign out_valid   = vld_p1;
  assign imm_ext     = headImm_p1;
  assign out_tag     = headTag_p1;
  assign out_illegal = headIll_p1;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench: RV32 and RV64 instances share stimulus; a negedge monitor
// pops expected entries whenever the head is consumed.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [31:0] in_tag = '0;

  logic        inReady32, outValid32, outIll32;
  logic        inReady64, outValid64, outIll64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;
  exp_t expQ[$];

  // Vectors: I(FFF), B, U, Z, reserved, S, J, IU, I(7FF)
  logic [24:0] vIns[9] = '{25'h1FFE000, 25'h1FC001D, 25'h1000000, 25'h0001500,
                           25'h1FFFFFF, 25'h0040003, 25'h0006020, 25'h1000000,
                           25'h0FFE000};
  logic [2:0]  vSrc[9] = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd7, 3'd1, 3'd3, 3'd6, 3'd0};
  logic [63:0] vExp[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                           64'hFFFF_FFFF_8000_0000, 64'h15, 64'h0, 64'h23,
                           64'h1802, 64'h800, 64'h7FF};
  logic        vIll[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  imm_ext_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(inReady32), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(outValid32), .out_ready(out_ready), .imm_ext(imm32),
    .out_tag(tag32), .out_illegal(outIll32)
  );

  imm_ext_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(inReady64), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(outValid64), .out_ready(out_ready), .imm_ext(imm64),
    .out_tag(tag64), .out_illegal(outIll64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drive a vector and hold it until accepted; returns at posedge+1 with in_valid still high.
  task automatic pushVec(input int idx, input logic [31:0] tag, output int waited);
    exp_t e;
    instr    = vIns[idx];
    imm_src  = vSrc[idx];
    in_tag   = tag;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (inReady32) break;
      waited++;
      if (waited > 100) begin
        check("push_timeout", 64'(waited), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    e.imm = vExp[idx];
    e.tag = tag;
    e.ill = vIll[idx];
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t monE;
  always @(negedge clk) begin
    if (reset_n && !flush && outValid32 && out_ready) begin
      if (expQ.size() == 0) begin
        check("unexpected_output", 64'(tag32), 64'hDEAD_BEEF);
      end else begin
        monE = expQ.pop_front();
        check("imm32", 64'(imm32), 64'(monE.imm[31:0]));
        check("imm64", imm64, monE.imm);
        check("tag32", 64'(tag32), 64'(monE.tag));
        check("tag64", 64'(tag64), 64'(monE.tag));
        check("illegal32", 64'(outIll32), 64'(monE.ill));
        check("illegal64", 64'(outIll64), 64'(monE.ill));
        check("valid64", 64'(outValid64), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(outValid32), 64'd0);
    check("rst_in_ready", 64'(inReady32), 64'd1);
    check("rst_imm32", 64'(imm32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_illegal", 64'(outIll32), 64'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // Single transfers through EMPTY -> ONE -> EMPTY, one per format
    for (int i = 0; i < 9; i++) begin
      pushVec(i, 32'h100 + i, w);
      if (i == 0) check("latency_valid", 64'(outValid32), 64'd1);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    // Back-to-back stream with out_ready high: no bubbles
    for (int i = 0; i < 8; i++) begin
      pushVec(i, 32'h200 + i, w);
      check("burst_wait", 64'(w), 64'd0);
    end
    check("burst_state_one", {62'd0, outValid32, inReady32}, 64'd3);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A, B fill the buffer, C held until the first pop
    out_ready = 1'b0;
    pushVec(0, 32'hA, w);
    pushVec(1, 32'hB, w);
    check("full_in_ready", 64'(inReady32), 64'd0);
    check("full_out_valid", 64'(outValid32), 64'd1);
    instr   = vIns[2];
    imm_src = vSrc[2];
    in_tag  = 32'hC;
    repeat (3) begin
      @(negedge clk);
      check("c_held", 64'(inReady32), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pushVec(2, 32'hC, w);
    check("ready_return", 64'(w), 64'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Flush in FULL with a pending push
    out_ready = 1'b0;
    pushVec(3, 32'hD0, w);
    pushVec(4, 32'hD1, w);
    instr    = vIns[5];
    imm_src  = vSrc[5];
    in_tag   = 32'hD2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    check("flush_out_valid", 64'(outValid32), 64'd0);
    check("flush_in_ready", 64'(inReady32), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_stays_empty", 64'(outValid32), 64'd0);
    pushVec(6, 32'hE0, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    pushVec(7, 32'hF0, w);
    pushVec(8, 32'hF1, w);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(outValid32), 64'd0);
    check("arst_in_ready", 64'(inReady32), 64'd1);
    check("arst_imm32", 64'(imm32), 64'd0);
    check("arst_imm64", imm64, 64'd0);
    check("arst_tag", 64'(tag64), 64'd0);
    check("arst_illegal", 64'(outIll32), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("post_rst_in_ready", 64'(inReady32), 64'd1);
    out_ready = 1'b1;
    pushVec(0, 32'hF2, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
